spm_ctrl_v2: RTL
================

# spm_ctrl_v2

Parametrised second-generation control unit for the stored-program machine (SPM). It sequences fetch, decode, execute, memory-read, memory-write and branch cycles, and drives the processing unit's register loads, bus multiplexer selects and memory control. Compared with the first-generation controller it adds:
- a configurable register-file size;
- a memory-ready stall handshake;
- carry-conditional branch and explicit halt instructions;
- illegal-opcode trapping;
- a retired-instruction counter.

## Interface
Parameters:
- WORD_SIZE, 8, instruction/data word width; must be ≥ OP_SIZE + 2·REG_BITS.
- OP_SIZE, 4, opcode field width (instruction MSBs).
- NUM_REGS, 4, general registers, power of 2, 2..16; REG_BITS = clog2(NUM_REGS).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instruction  in  WORD_SIZE  IR contents; opcode = [WORD_SIZE-1 -: OP_SIZE], src = next REG_BITS below, dest = [REG_BITS-1:0].
- zero  in  1  ALU zero flag (registered, from processing unit).
- carry  in  1  ALU carry flag (registered).
- mem_rdy  in  1  memory completes the current read/write this cycle.
- load_reg  out  NUM_REGS  one-hot register load strobes.
- load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z  out  1 each  processing-unit strobes.
- sel_bus1  out  clog2(NUM_REGS+1)  Bus_1 mux: 0..NUM_REGS-1 = register, NUM_REGS = PC.
- sel_bus2  out  2  Bus_2 mux: 0 = ALU, 1 = Bus_1, 2 = memory.
- write  out  1  memory write strobe.
- halted  out  1  FSM in HALT.
- illegal_op  out  1  sticky; set when HALT is entered via an undefined opcode.
- instr_cnt  out  CNT_W  retired-instruction count.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, BRC=9, HLT=15. All other values are illegal.
- States: IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT. Every state has a unique encoding.
- IDLE → FET1.
- FET1: sel_bus1=PC, sel_bus2=1, load_add_r → FET2.
- FET2 (memory state): sel_bus2=2, load_ir, inc_pc → DEC.
- DEC, by opcode:
  - NOP → FET1.
  - ADD/SUB/AND: sel_bus1=src, sel_bus2=1, load_reg_y → EX1.
  - NOT: sel_bus1=src, sel_bus2=0, load_reg_z, load_reg[dest] → FET1.
  - RD/WR/BR: sel_bus1=PC, sel_bus2=1, load_add_r → RD1/WR1/BR1.
  - BRZ: if zero, behaves as BR; else inc_pc → FET1.
  - BRC: same as BRZ, conditioned on carry.
  - HLT → HALT.
  - Illegal opcode → HALT and set illegal_op.
- EX1: sel_bus2=0, load_reg_z, load_reg[dest], sel_bus1=dest → FET1.
- RD1 (memory state): sel_bus2=2, load_add_r, inc_pc → RD2.
- RD2 (memory state): sel_bus2=2, load_reg[dest] → FET1.
- WR1 (memory state): sel_bus2=2, load_add_r, inc_pc → WR2.
- WR2 (memory state): sel_bus1=src, write → FET1.
- BR1 (memory state): sel_bus2=2, load_add_r → BR2.
- BR2 (memory state): sel_bus2=2, load_pc → FET1.
- HALT: absorbing; only rst leaves it.
- Memory-state stall rule: while mem_rdy=0, the FSM holds state and suppresses all load/inc strobes. write and the select outputs stay asserted. Strobes fire only in the cycle where mem_rdy=1.
- instr_cnt increments by 1 on every transition into FET1 from DEC, EX1, RD2, WR2 or BR2. It wraps modulo 2^CNT_W.
- Idle output defaults: strobes 0, sel_bus1=0, sel_bus2=1. No X values are ever driven.

## Timing
- Outputs are combinational from state, instruction, zero, carry and mem_rdy. State and counters are registered.
- Reset values: state=IDLE, all strobes and write 0, sel_bus1=0, sel_bus2=1, halted=0, illegal_op=0, instr_cnt=0.
- Latency with mem_rdy held 1:
  - NOP: 3 cycles.
  - ALU op: 4 cycles.
  - NOT: 3 cycles.
  - RD/WR/taken branch: 5 cycles.
  - Untaken branch: 3 cycles.
  - Each mem_rdy=0 cycle adds one cycle.
- Reset mid-instruction: the FSM returns to IDLE immediately, asynchronously; no partial strobes follow.
- instr_cnt wrap and a retire in the same cycle: the counter goes to 0.

## Structure
- Package spm_pkg holds the opcode constants, state enum, and the sel_bus2 encodings (ALU/BUS1/MEM).
- One sub-module, spm_ctrl_decode: combinational opcode/src/dest decode producing op-class flags and the illegal flag. The FSM, strobe generation and counter remain in spm_ctrl_v2.

## Test plan
- Reset, then NOP with mem_rdy=1 → FET1, FET2, DEC, FET1; instr_cnt=1; load_ir pulses once.
- ADD src=R1, dest=R2 (0x16) → DEC: sel_bus1=1, load_reg_y; EX1: sel_bus2=0, load_reg=4'b0100, load_reg_z.
- RD dest=R3 with mem_rdy low for 2 cycles in RD2 → RD2 held 3 cycles; load_reg=4'b1000 only in the final cycle.
- BRZ with zero=0 → inc_pc in DEC, next state FET1. BRC with carry=1 → BR1, BR2, load_pc.
- Opcode 0xB → HALT; halted=1, illegal_op=1, outputs stay at idle defaults; rst low mid-HALT clears both flags.
- NUM_REGS=8, WORD_SIZE=12: NOT src=R5, dest=R6 → sel_bus1=5, load_reg=8'b0100_0000; sel_bus1=8 during FET1.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the SPM second-generation controller:
// opcode values, FSM state encoding and Bus_2 mux selects.
package spm_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_AND = 3;
    localparam int OP_NOT = 4;
    localparam int OP_RD  = 5;
    localparam int OP_WR  = 6;
    localparam int OP_BR  = 7;
    localparam int OP_BRZ = 8;
    localparam int OP_BRC = 9;
    localparam int OP_HLT = 15;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'd0,
        BUS2_BUS1 = 2'd1,
        BUS2_MEM  = 2'd2
    } bus2_sel_t;

endpackage

// File: rtl/spm_ctrl_decode.sv
// Combinational instruction-register decode: splits out src/dest fields and
// classifies the opcode, flagging anything outside the defined set as illegal.
module spm_ctrl_decode
    import spm_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int NUM_REGS  = 4
) (
    input  logic [WORD_SIZE-1:0]         instruction_i,
    output logic [$clog2(NUM_REGS)-1:0]  src_o,
    output logic [$clog2(NUM_REGS)-1:0]  dest_o,
    output logic                         op_nop_o,
    output logic                         op_alu_o,
    output logic                         op_not_o,
    output logic                         op_rd_o,
    output logic                         op_wr_o,
    output logic                         op_br_o,
    output logic                         op_brz_o,
    output logic                         op_brc_o,
    output logic                         op_hlt_o,
    output logic                         illegal_o
);

    localparam int REG_BITS = $clog2(NUM_REGS);

    logic [OP_SIZE-1:0] op;

    assign op     = instruction_i[WORD_SIZE-1 -: OP_SIZE];
    assign src_o  = instruction_i[WORD_SIZE-OP_SIZE-1 -: REG_BITS];
    assign dest_o = instruction_i[REG_BITS-1:0];

    assign op_nop_o = (op == OP_SIZE'(OP_NOP));
    assign op_alu_o = (op == OP_SIZE'(OP_ADD)) || (op == OP_SIZE'(OP_SUB)) ||
                      (op == OP_SIZE'(OP_AND));
    assign op_not_o = (op == OP_SIZE'(OP_NOT));
    assign op_rd_o  = (op == OP_SIZE'(OP_RD));
    assign op_wr_o  = (op == OP_SIZE'(OP_WR));
    assign op_br_o  = (op == OP_SIZE'(OP_BR));
    assign op_brz_o = (op == OP_SIZE'(OP_BRZ));
    assign op_brc_o = (op == OP_SIZE'(OP_BRC));
    assign op_hlt_o = (op == OP_SIZE'(OP_HLT));

    assign illegal_o = !(op_nop_o || op_alu_o || op_not_o || op_rd_o || op_wr_o ||
                         op_br_o || op_brz_o || op_brc_o || op_hlt_o);

endmodule

// File: rtl/spm_ctrl_v2.sv
// SPM control unit: fetch/decode/execute FSM with memory-ready stalls,
// conditional branches, halt/illegal trapping and a retired-instruction counter.
module spm_ctrl_v2
    import spm_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int NUM_REGS  = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_SIZE-1:0]             instruction,
    input  logic                             zero,
    input  logic                             carry,
    input  logic                             mem_rdy,
    output logic [NUM_REGS-1:0]              load_reg,
    output logic                             load_pc,
    output logic                             inc_pc,
    output logic                             load_ir,
    output logic                             load_add_r,
    output logic                             load_reg_y,
    output logic                             load_reg_z,
    output logic [$clog2(NUM_REGS+1)-1:0]    sel_bus1,
    output logic [1:0]                       sel_bus2,
    output logic                             write,
    output logic                             halted,
    output logic                             illegal_op,
    output logic [CNT_W-1:0]                 instr_cnt
);

    localparam int REG_BITS = $clog2(NUM_REGS);
    localparam int SB1_W    = $clog2(NUM_REGS+1);
    localparam logic [SB1_W-1:0] SEL_PC = SB1_W'(NUM_REGS);

    state_t              state_q, state_d;
    logic                illegal_q;
    logic [CNT_W-1:0]    cnt_q;
    bus2_sel_t           sel2;
    logic                retire, trap;

    logic [REG_BITS-1:0] src, dest;
    logic                d_nop, d_alu, d_not, d_rd, d_wr, d_br, d_brz, d_brc, d_hlt, d_ill;
    logic [SB1_W-1:0]    src_sel, dest_sel;
    logic [NUM_REGS-1:0] dest_oh;
    logic                br_taken;

    spm_ctrl_decode #(
        .WORD_SIZE (WORD_SIZE),
        .OP_SIZE   (OP_SIZE),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .instruction_i (instruction),
        .src_o         (src),
        .dest_o        (dest),
        .op_nop_o      (d_nop),
        .op_alu_o      (d_alu),
        .op_not_o      (d_not),
        .op_rd_o       (d_rd),
        .op_wr_o       (d_wr),
        .op_br_o       (d_br),
        .op_brz_o      (d_brz),
        .op_brc_o      (d_brc),
        .op_hlt_o      (d_hlt),
        .illegal_o     (d_ill)
    );

    assign src_sel  = SB1_W'(src);
    assign dest_sel = SB1_W'(dest);
    assign dest_oh  = NUM_REGS'(1) << dest;
    assign br_taken = (d_brz && zero) || (d_brc && carry);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (trap)   illegal_q <= 1'b1;
            if (retire) cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // Memory states only advance and fire strobes when mem_rdy is high;
    // selects and write are held throughout a stall.
    always_comb begin
        state_d    = state_q;
        load_reg   = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel_bus1   = '0;
        sel2       = BUS2_BUS1;
        write      = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                sel_bus1   = SEL_PC;
                load_add_r = 1'b1;
                state_d    = S_FET2;
            end
            S_FET2: begin
                sel2 = BUS2_MEM;
                if (mem_rdy) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (d_ill || d_hlt) begin
                    state_d = S_HALT;
                    trap    = d_ill;
                end else if (d_alu) begin
                    sel_bus1   = src_sel;
                    load_reg_y = 1'b1;
                    state_d    = S_EX1;
                end else if (d_not) begin
                    sel_bus1   = src_sel;
                    sel2       = BUS2_ALU;
                    load_reg_z = 1'b1;
                    load_reg   = dest_oh;
                    state_d    = S_FET1;
                    retire     = 1'b1;
                end else if (d_rd || d_wr || d_br || br_taken) begin
                    sel_bus1   = SEL_PC;
                    load_add_r = 1'b1;
                    state_d    = d_rd ? S_RD1 : (d_wr ? S_WR1 : S_BR1);
                end else if (d_brz || d_brc) begin
                    // Untaken branch skips the target-address word.
                    inc_pc  = 1'b1;
                    state_d = S_FET1;
                    retire  = 1'b1;
                end else begin
                    state_d = S_FET1;
                    retire  = d_nop;
                end
            end
            S_EX1: begin
                sel_bus1   = dest_sel;
                sel2       = BUS2_ALU;
                load_reg_z = 1'b1;
                load_reg   = dest_oh;
                state_d    = S_FET1;
                retire     = 1'b1;
            end
            S_RD1, S_WR1: begin
                sel2 = BUS2_MEM;
                if (mem_rdy) begin
                    load_add_r = 1'b1;
                    inc_pc     = 1'b1;
                    state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
                end
            end
            S_RD2: begin
                sel2 = BUS2_MEM;
                if (mem_rdy) begin
                    load_reg = dest_oh;
                    state_d  = S_FET1;
                    retire   = 1'b1;
                end
            end
            S_WR2: begin
                sel_bus1 = src_sel;
                write    = 1'b1;
                if (mem_rdy) begin
                    state_d = S_FET1;
                    retire  = 1'b1;
                end
            end
            S_BR1: begin
                sel2 = BUS2_MEM;
                if (mem_rdy) begin
                    load_add_r = 1'b1;
                    state_d    = S_BR2;
                end
            end
            S_BR2: begin
                sel2 = BUS2_MEM;
                if (mem_rdy) begin
                    load_pc = 1'b1;
                    state_d = S_FET1;
                    retire  = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign sel_bus2   = sel2;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;
    assign instr_cnt  = cnt_q;

endmodule
